btb_predictor: RTL and testbench



---
 rtl/btb_predictor_pkg.sv | 18 +
 rtl/btb_predictor_sat_ctr.sv | 19 +
 rtl/btb_predictor.sv | 111 +++++++++++
 tb/tb_btb_predictor.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/btb_predictor_pkg.sv
// Shared constants for the branch target buffer: default depth, address bus
// width and the 2-bit direction counter encodings.
package btb_predictor_pkg;

  localparam int BTB_ENTRIES = 64;
  localparam int ADDR_BUS    = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = WNT;
  localparam ctr_e CTR_ALLOC = WT;

endpackage

// File: rtl/btb_predictor_sat_ctr.sv
// Combinational next-state function of a 2-bit saturating direction counter.
module btb_sat_ctr
  import btb_predictor_pkg::*;
(
  input  ctr_e i_ctr,
  input  logic i_taken,
  output ctr_e o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    if (i_taken) begin
      if (i_ctr != ST) o_ctr = ctr_e'(i_ctr + 2'd1);
    end else begin
      if (i_ctr != SNT) o_ctr = ctr_e'(i_ctr - 2'd1);
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, zero-latency lookup in IF.
// Define BTB_STATS_EN to add the lookup/hit/mispredict statistics counters.
module btb_predictor
  import btb_predictor_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_BUS-1:0] pc,
  output logic                btb_pre_taken,
  output logic [ADDR_BUS-1:0] btb_pre_addr,
  input  logic                update_en,
  input  logic [ADDR_BUS-1:0] update_pc,
  input  logic                update_taken,
  input  logic [ADDR_BUS-1:0] update_target,
  input  logic                invalidate
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]         stat_lookups,
  output logic [31:0]         stat_hits,
  output logic [31:0]         stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] r_valid;
  ctr_e               r_ctr [ENTRIES];
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [29:0]        r_tgt [ENTRIES];

  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_tag;
  logic [TAG_W-1:0] w_u_tag;
  logic             w_hit;
  logic             w_u_hit;
  ctr_e             w_u_ctr_nxt;
  logic             w_unused;

  assign w_idx   = pc[IDX_W+1:2];
  assign w_tag   = pc[31:IDX_W+2];
  assign w_u_idx = update_pc[IDX_W+1:2];
  assign w_u_tag = update_pc[31:IDX_W+2];

  assign w_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

  // Byte offsets never index or tag; targets are stored word aligned.
  assign w_unused = ^{pc[1:0], update_pc[1:0], update_target[1:0]};

  assign btb_pre_taken = w_hit && r_ctr[w_idx][1];
  assign btb_pre_addr  = btb_pre_taken ? {r_tgt[w_idx], 2'b00} : '0;

  btb_sat_ctr u_sat_ctr (
    .i_ctr   (r_ctr[w_u_idx]),
    .i_taken (update_taken),
    .o_ctr   (w_u_ctr_nxt)
  );

  // Valid bits and counters: invalidate outranks training in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_RESET;
    end else if (invalidate) begin
      r_valid <= '0;
    end else if (update_en) begin
      if (w_u_hit) begin
        r_ctr[w_u_idx] <= w_u_ctr_nxt;
      end else if (update_taken) begin
        r_valid[w_u_idx] <= 1'b1;
        r_ctr[w_u_idx]   <= CTR_ALLOC;
      end
    end
  end

  // On a hit the tag rewrite is a no-op, so any taken update writes both.
  always_ff @(posedge clk) begin
    if (!invalidate && update_en && update_taken) begin
      r_tag[w_u_idx] <= w_u_tag;
      r_tgt[w_u_idx] <= update_target[31:2];
    end
  end

`ifdef BTB_STATS_EN
  logic        w_u_pred_taken;
  logic [31:0] w_u_pred_addr;
  logic        w_mispredict;

  assign w_u_pred_taken = w_u_hit && r_ctr[w_u_idx][1];
  assign w_u_pred_addr  = w_u_pred_taken ? {r_tgt[w_u_idx], 2'b00} : '0;
  assign w_mispredict   = (w_u_pred_taken != update_taken) ||
                          (update_taken && (w_u_pred_addr != update_target));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lookups     <= '0;
      stat_hits        <= '0;
      stat_mispredicts <= '0;
    end else begin
      stat_lookups <= stat_lookups + 32'd1;
      if (w_hit) stat_hits <= stat_hits + 32'd1;
      if (update_en && w_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed and randomized bench for btb_predictor against an array-based
// model of the BTB rules.
module tb_btb_predictor;

  localparam int ENTRIES = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        btb_pre_taken;
  logic [31:0] btb_pre_addr;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        invalidate;
`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_hits;
  logic [31:0] stat_mispredicts;
`endif

  always #5 clk = ~clk;

  btb_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .btb_pre_taken (btb_pre_taken),
    .btb_pre_addr  (btb_pre_addr),
    .update_en     (update_en),
    .update_pc     (update_pc),
    .update_taken  (update_taken),
    .update_target (update_target),
    .invalidate    (invalidate)
`ifdef BTB_STATS_EN
    ,
    .stat_lookups     (stat_lookups),
    .stat_hits        (stat_hits),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit          m_valid [ENTRIES];
  logic [31:0] m_tagv  [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32'd4) % 32'(ENTRIES));
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / (32'd4 * 32'(ENTRIES));
  endfunction

  function automatic void m_reset();
    for (int k = 0; k < ENTRIES; k++) begin
      m_valid[k] = 1'b0;
      m_ctr[k]   = 1;
    end
  endfunction

  function automatic void m_predict(input logic [31:0] a, output bit tk, output logic [31:0] addr);
    int  i   = idx_of(a);
    bit  hit = m_valid[i] && (m_tagv[i] == tag_of(a));
    tk   = hit && (m_ctr[i] >= 2);
    addr = tk ? m_tgt[i] : 32'h0;
  endfunction

  function automatic void m_update(input bit en, input logic [31:0] upc, input bit tk,
                                   input logic [31:0] tgt, input bit inv);
    int  i   = idx_of(upc);
    bit  hit = m_valid[i] && (m_tagv[i] == tag_of(upc));
    if (inv) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
      return;
    end
    if (!en) return;
    if (hit) begin
      if (tk) begin
        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_tgt[i] = tgt & ~32'h3;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (tk) begin
      m_valid[i] = 1'b1;
      m_tagv[i]  = tag_of(upc);
      m_tgt[i]   = tgt & ~32'h3;
      m_ctr[i]   = 2;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check lookup against the model, train at posedge.
  task automatic step(input logic [31:0] p, input bit en, input logic [31:0] upc, input bit tk,
                      input logic [31:0] tgt, input bit inv, input string name);
    bit          et;
    logic [31:0] ea;
    pc = p; update_en = en; update_pc = upc; update_taken = tk;
    update_target = tgt; invalidate = inv;
    #1;
    m_predict(p, et, ea);
    chk({name, "_taken"}, 32'(btb_pre_taken), 32'(et));
    chk({name, "_addr"}, btb_pre_addr, ea);
    @(posedge clk);
    m_update(en, upc, tk, tgt, inv);
    @(negedge clk);
  endtask

  // Pure lookup checked against hand-derived constants.
  task automatic look(input logic [31:0] p, input bit etk, input logic [31:0] eaddr,
                      input string name);
    pc = p; update_en = 1'b0; update_pc = '0; update_taken = 1'b0;
    update_target = '0; invalidate = 1'b0;
    #1;
    chk({name, "_taken"}, 32'(btb_pre_taken), 32'(etk));
    chk({name, "_addr"}, btb_pre_addr, eaddr);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pool_pc(input int unsigned r);
    return 32'hBFC0_0000 + 32'((r % 8) * 4) + 32'(((r / 8) % 2) * 256);
  endfunction

  initial begin
    rst = 1'b0; pc = '0; update_en = 1'b0; update_pc = '0;
    update_taken = 1'b0; update_target = '0; invalidate = 1'b0;
    #1 rst = 1'b1;
    m_reset();
    @(negedge clk);
    #1;
    chk("reset_taken", 32'(btb_pre_taken), 32'h0);
    chk("reset_addr", btb_pre_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) look(32'hBFC0_0000, 1'b0, 32'h0, "t1_cold");

    step(32'hBFC0_0010, 1'b1, 32'hBFC0_0010, 1'b1, 32'hBFC0_0100, 1'b0, "t2_same_cycle");
    look(32'hBFC0_0010, 1'b1, 32'hBFC0_0100, "t2_next");

    step(32'hBFC0_0010, 1'b1, 32'hBFC0_0010, 1'b0, 32'h0, 1'b0, "t3_nt1");
    step(32'hBFC0_0010, 1'b1, 32'hBFC0_0010, 1'b0, 32'h0, 1'b0, "t3_nt2");
    look(32'hBFC0_0010, 1'b0, 32'h0, "t3_ctr0");
    step(32'hBFC0_0010, 1'b1, 32'hBFC0_0010, 1'b1, 32'hBFC0_0100, 1'b0, "t3_tk1");
    look(32'hBFC0_0010, 1'b0, 32'h0, "t3_ctr1");
    step(32'hBFC0_0010, 1'b1, 32'hBFC0_0010, 1'b1, 32'hBFC0_0100, 1'b0, "t3_tk2");
    look(32'hBFC0_0010, 1'b1, 32'hBFC0_0100, "t3_ctr2");

    step(32'h0, 1'b1, 32'hBFC0_0010, 1'b1, 32'hBFC0_0100, 1'b0, "t4_a");
    step(32'h0, 1'b1, 32'hBFC0_0110, 1'b1, 32'h8000_0000, 1'b0, "t4_b");
    look(32'hBFC0_0010, 1'b0, 32'h0, "t4_old_tag");
    look(32'hBFC0_0110, 1'b1, 32'h8000_0000, "t4_new_tag");

    for (int i = 0; i < 4; i++)
      step(32'h0, 1'b1, 32'h1000 + 32'(4 * i), 1'b1, 32'h2000 + 32'(16 * i), 1'b0, "t5_fill");
    look(32'h100C, 1'b1, 32'h2030, "t5_filled");
    step(32'h0, 1'b1, 32'h2010, 1'b1, 32'h5000, 1'b1, "t5_inv");
    for (int i = 0; i < 4; i++) look(32'h1000 + 32'(4 * i), 1'b0, 32'h0, "t5_miss");
    look(32'h2010, 1'b0, 32'h0, "t5_dropped");
    look(32'hBFC0_0110, 1'b0, 32'h0, "t5_old");

    step(32'h0, 1'b1, 32'h3000, 1'b1, 32'h1234_567B, 1'b0, "t6_alloc");
    look(32'h3000, 1'b1, 32'h1234_5678, "t6_hit_aligned");
    pc = 32'h3000;
    #1;
    chk("t6_pre_rst_taken", 32'(btb_pre_taken), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_taken", 32'(btb_pre_taken), 32'h0);
    chk("t6_async_addr", btb_pre_addr, 32'h0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    look(32'h3000, 1'b0, 32'h0, "t6_after");

    for (int i = 0; i < 400; i++) begin
      step(pool_pc($urandom), 1'($urandom % 2), pool_pc($urandom), 1'($urandom % 3 != 0),
           $urandom, ($urandom % 40) == 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
